// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: opcode
// encodings and the output-stage state encoding.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Occupancy of the two-entry output stage (M only, or M plus skid S).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } lu_state_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Combinational core: maps (op, a, b) to a bitwise result plus its
// zero and parity flags. No carries, no width growth.
module logic_unit_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero,
    output logic             o_par
);

    // Gate function select; operand B is ignored for NOT and PASS.
    always_comb begin
        o_y = i_a;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XOR:  o_y = i_a ^ i_b;
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_NOT:  o_y = ~i_a;
            default: o_y = i_a;
        endcase
    end

    assign o_zero = (o_y == '0);
    assign o_par  = ^o_y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a valid/ready input, 1-cycle
// latency and a 2-entry skid-buffered output stage (main M, skid S).
// in_ready is a flop so it never depends combinationally on out_ready.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_par
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             par;
    } res_t;

    lu_state_t        r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_m_y;
    logic [WIDTH-1:0] r_s_y;

    res_t             w_res;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_m;
    logic             w_load_s;
    logic             w_m_from_s;

    logic_unit_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_op   (in_op),
        .i_a    (in_a),
        .i_b    (in_b),
        .o_y    (w_res.y),
        .o_zero (w_res.zero),
        .o_par  (w_res.par)
    );

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // M takes a fresh result when it is (or is about to become) the head,
    // and takes the skid entry when draining from FULL.
    assign w_load_m   = ((r_state == ST_EMPTY) && w_in_fire) ||
                        ((r_state == ST_ONE) && w_in_fire && w_out_fire) ||
                        ((r_state == ST_FULL) && w_out_fire);
    assign w_load_s   = (r_state == ST_ONE) && w_in_fire && !w_out_fire;
    assign w_m_from_s = (r_state == ST_FULL);

    // Occupancy FSM with registered in_ready / out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result storage for M and S; M holds steady while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_y <= '0;
            r_s_y <= '0;
        end else begin
            if (w_load_s) r_s_y <= w_res.y;
            if (w_load_m) r_m_y <= w_m_from_s ? r_s_y : w_res.y;
        end
    end

    generate
        if (FLAGS_EN) begin : g_flags
            logic r_m_zero, r_m_par, r_s_zero, r_s_par;

            // Flag storage follows the same load pattern as the result bits.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_zero <= 1'b0;
                    r_m_par  <= 1'b0;
                    r_s_zero <= 1'b0;
                    r_s_par  <= 1'b0;
                end else begin
                    if (w_load_s) begin
                        r_s_zero <= w_res.zero;
                        r_s_par  <= w_res.par;
                    end
                    if (w_load_m) begin
                        r_m_zero <= w_m_from_s ? r_s_zero : w_res.zero;
                        r_m_par  <= w_m_from_s ? r_s_par  : w_res.par;
                    end
                end
            end

            assign out_zero = r_m_zero;
            assign out_par  = r_m_par;
        end else begin : g_no_flags
            assign out_zero = 1'b0;
            assign out_par  = 1'b0;
        end
    endgenerate

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_m_y;

endmodule
